cordic_rot_seq: RTL and testbench

CORDIC_ROT_SEQ -- requirements
Module: cordic_rot_seq

---
 rtl/cordic_rot_seq.sv | 183 ++++++++++++++++++
 tb/tb_cordic_rot_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rot_seq.sv
// Iterative CORDIC rotator: quadrant pre-rotation, one micro-rotation per clock,
// then a single gain-correction cycle before the result is offered downstream.
module cordic_rot_seq #(
   parameter int unsigned          N    = 16,
   parameter int unsigned          DW   = 16,
   parameter int unsigned          AW   = 16,
   parameter logic [N-1:0][AW-1:0] ATAN = '0,
   parameter int unsigned          KW   = 16,
   parameter int unsigned          K    = 39797
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 s_valid_i,
   output logic                 s_ready_o,
   input  logic [1:0]           quadrant_i,
   input  logic [AW-1:0]        angle_i,
   input  logic signed [DW-1:0] x_i,
   input  logic signed [DW-1:0] y_i,
   output logic                 m_valid_o,
   input  logic                 m_ready_i,
   output logic signed [DW-1:0] x_o,
   output logic signed [DW-1:0] y_o,
   output logic                 busy_o
);

   localparam int unsigned          WW     = DW + 2;
   localparam int unsigned          PW     = WW + KW;
   localparam int unsigned          CW     = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0]        LAST   = CW'(N - 1);
   localparam logic [KW-1:0]        K_U    = KW'(K);
   localparam logic signed [DW-1:0] DW_MIN = {1'b1, {(DW-1){1'b0}}};
   localparam logic signed [DW-1:0] DW_MAX = {1'b0, {(DW-1){1'b1}}};

   typedef enum logic [1:0] {IDLE, ROT, SCALE, OUT} state_t;

   state_t               state_reg, state_next;
   logic [CW-1:0]        cnt_reg;
   logic signed [WW-1:0] x_reg, y_reg;
   logic signed [AW:0]   a_reg;
   logic signed [DW-1:0] x_out_reg, y_out_reg;

   logic signed [DW-1:0] qx, qy;
   logic signed [WW-1:0] x_next, y_next;
   logic signed [AW:0]   a_next;
   logic signed [AW:0]   atan_step;
   logic signed [WW-1:0] work [2];
   logic signed [DW-1:0] scaled [2];

   // The most negative value has no positive twin; clamp it instead of wrapping.
   function automatic logic signed [DW-1:0] neg_sat(input logic signed [DW-1:0] v);
      if (v == DW_MIN) begin
         neg_sat = DW_MAX;
      end else begin
         neg_sat = -v;
      end
   endfunction

   function automatic logic signed [DW-1:0] scale_sat(input logic signed [WW-1:0] v);
      logic signed [PW-1:0] prod;
      logic signed [WW:0]   rnd;
      prod = $signed({{KW{v[WW-1]}}, v}) * $signed({{WW{1'b0}}, K_U});
      rnd  = $signed({prod[PW-1], prod[PW-1:KW]}) + $signed({{WW{1'b0}}, prod[KW-1]});
      if (rnd[WW:DW-1] == {(WW-DW+2){rnd[WW]}}) begin
         scale_sat = rnd[DW-1:0];
      end else if (rnd[WW]) begin
         scale_sat = DW_MIN;
      end else begin
         scale_sat = DW_MAX;
      end
   endfunction

   always_comb begin
      qx = x_i;
      qy = y_i;
      case (quadrant_i)
         2'd1: begin
            qx = neg_sat(y_i);
            qy = x_i;
         end
         2'd2: begin
            qx = neg_sat(x_i);
            qy = neg_sat(y_i);
         end
         2'd3: begin
            qx = y_i;
            qy = neg_sat(x_i);
         end
         default: begin
            qx = x_i;
            qy = y_i;
         end
      endcase
   end

   // Rotation direction follows the sign of the residual angle.
   always_comb begin
      atan_step = $signed({1'b0, ATAN[cnt_reg]});
      if (!a_reg[AW]) begin
         x_next = x_reg - (y_reg >>> cnt_reg);
         y_next = y_reg + (x_reg >>> cnt_reg);
         a_next = a_reg - atan_step;
      end else begin
         x_next = x_reg + (y_reg >>> cnt_reg);
         y_next = y_reg - (x_reg >>> cnt_reg);
         a_next = a_reg + atan_step;
      end
   end

   assign work[0] = x_reg;
   assign work[1] = y_reg;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_scale
         assign scaled[gi] = scale_sat(work[gi]);
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (s_valid_i) state_next = ROT;
         ROT:     if (cnt_reg == LAST) state_next = SCALE;
         SCALE:   state_next = OUT;
         OUT:     if (m_ready_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      s_ready_o = (state_reg == IDLE);
      busy_o    = (state_reg != IDLE);
      m_valid_o = (state_reg == OUT);
   end

   // Counter parks on its last value until the next accept reloads it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_reg   <= '0;
         x_reg     <= '0;
         y_reg     <= '0;
         a_reg     <= '0;
         x_out_reg <= '0;
         y_out_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (s_valid_i) begin
                  x_reg   <= $signed({{2{qx[DW-1]}}, qx});
                  y_reg   <= $signed({{2{qy[DW-1]}}, qy});
                  a_reg   <= $signed({1'b0, angle_i});
                  cnt_reg <= '0;
               end
            end
            ROT: begin
               x_reg <= x_next;
               y_reg <= y_next;
               a_reg <= a_next;
               if (cnt_reg != LAST) begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            SCALE: begin
               x_out_reg <= scaled[0];
               y_out_reg <= scaled[1];
            end
            default: begin
            end
         endcase
      end
   end

   assign x_o = x_out_reg;
   assign y_o = y_out_reg;

endmodule

// File: tb/tb_cordic_rot_seq.sv
// Bench for cordic_rot_seq: directed and random rotations compared with an ideal
// floating-point rotation; a scoreboard queue decouples stimulus from checking.
module tb_cordic_rot_seq;

   localparam int  N       = 16;
   localparam int  DW      = 16;
   localparam int  AW      = 16;
   localparam int  KW      = 16;
   localparam int  TOL_DIR = 3;
   localparam int  TOL_RND = 6;
   localparam int  LIMIT   = 200;
   localparam real PI      = 3.14159265358979323846;
   localparam logic [N-1:0][AW-1:0] ATAN_T = {
      16'd1, 16'd3, 16'd5, 16'd10, 16'd20, 16'd41, 16'd81, 16'd163,
      16'd326, 16'd652, 16'd1303, 16'd2604, 16'd5188, 16'd10221, 16'd19344, 16'd32768};

   logic                 clk      = 1'b0;
   logic                 rst_n    = 1'b0;
   logic                 s_valid  = 1'b0;
   logic                 m_ready  = 1'b0;
   logic [1:0]           quadrant = '0;
   logic [AW-1:0]        angle    = '0;
   logic signed [DW-1:0] x_i      = '0;
   logic signed [DW-1:0] y_i      = '0;
   logic                 s_ready, m_valid, busy;
   logic signed [DW-1:0] x_o, y_o;

   typedef struct {
      int xe;
      int ye;
      int xt;
      int yt;
      int acc;
      int id;
   } exp_t;

   exp_t sb[$];
   int   n_total  = 0;
   int   n_bad    = 0;
   int   cyc      = 0;
   int   n_sent   = 0;
   int   rdy_mode = 0;

   logic                 prev_valid = 1'b0;
   logic signed [DW-1:0] hold_x     = '0;
   logic signed [DW-1:0] hold_y     = '0;

   cordic_rot_seq #(
      .N(N), .DW(DW), .AW(AW), .ATAN(ATAN_T), .KW(KW), .K(39797)
   ) dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .s_valid_i(s_valid),
      .s_ready_o(s_ready),
      .quadrant_i(quadrant),
      .angle_i(angle),
      .x_i(x_i),
      .y_i(y_i),
      .m_valid_o(m_valid),
      .m_ready_i(m_ready),
      .x_o(x_o),
      .y_o(y_o),
      .busy_o(busy)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input int act, input int want, input int tol);
      n_total++;
      if (act < want - tol || act > want + tol) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d +/- %0d (cycle %0d)", name, act, want, tol, cyc);
      end
   endfunction

   function automatic int clamp(input real v);
      int r;
      r = int'(v);
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      return r;
   endfunction

   // Ideal rotation by q*pi/2 + a*(pi/2)/2^16, rounded and clipped to 16 bits.
   function automatic void model(input logic [1:0] q, input int a, input int x, input int y,
                                 output int xe, output int ye);
      real th;
      th = (real'(int'(q)) * 65536.0 + real'(a)) * PI / 131072.0;
      xe = clamp(real'(x) * $cos(th) - real'(y) * $sin(th));
      ye = clamp(real'(x) * $sin(th) + real'(y) * $cos(th));
   endfunction

   task automatic drive(input logic [1:0] q, input int a, input int x, input int y);
      s_valid  = 1'b1;
      quadrant = q;
      angle    = AW'(a);
      x_i      = DW'(x);
      y_i      = DW'(y);
   endtask

   task automatic accept(input logic [1:0] q, input int a, input int x, input int y,
                         input int xt, input int yt, output int waited);
      exp_t e;
      waited = 0;
      forever begin
         @(negedge clk);
         waited++;
         if (s_ready) break;
         if (waited > LIMIT) begin
            n_total++;
            n_bad++;
            $display("FAIL accept_timeout: got s_ready=0 for %0d cycles, want 1", waited);
            s_valid = 1'b0;
            return;
         end
      end
      model(q, a, x, y, e.xe, e.ye);
      e.xt  = xt;
      e.yt  = yt;
      e.acc = cyc;
      e.id  = n_sent;
      n_sent++;
      sb.push_back(e);
      $display("send id=%0d q=%0d a=%0d x=%0d y=%0d exp=(%0d,%0d)", e.id, q, a, x, y, e.xe, e.ye);
      @(posedge clk);
      #1;
      s_valid  = 1'b0;
      quadrant = 2'($urandom);
      angle    = AW'($urandom);
      x_i      = DW'($urandom);
      y_i      = DW'($urandom);
   endtask

   task automatic send(input logic [1:0] q, input int a, input int x, input int y,
                       input int xt, input int yt);
      int w;
      @(posedge clk);
      #1;
      drive(q, a, x, y);
      accept(q, a, x, y, xt, yt, w);
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (sb.size() != 0 && k < 4 * LIMIT) begin
         @(negedge clk);
         k++;
      end
      check("drain_pending", sb.size(), 0, 0);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ($urandom_range(0, 3) != 0);
            default: m_ready = 1'b0;
         endcase
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_valid = 1'b0;
         end else begin
            if (m_valid) begin
               if (!prev_valid) begin
                  hold_x = x_o;
                  hold_y = y_o;
                  if (sb.size() == 0) begin
                     n_total++;
                     n_bad++;
                     $display("FAIL unexpected_valid: got m_valid=1 at cycle %0d, want 0", cyc);
                  end else begin
                     check($sformatf("latency[%0d]", sb[0].id), cyc - sb[0].acc, N + 2, 0);
                  end
               end else begin
                  check("hold_x", int'(x_o), int'(hold_x), 0);
                  check("hold_y", int'(y_o), int'(hold_y), 0);
               end
               if (m_ready && sb.size() > 0) begin
                  e = sb.pop_front();
                  check($sformatf("x_o[%0d]", e.id), int'(x_o), e.xe, e.xt);
                  check($sformatf("y_o[%0d]", e.id), int'(y_o), e.ye, e.yt);
                  $display("recv id=%0d x_o=%0d y_o=%0d", e.id, x_o, y_o);
               end
            end
            prev_valid = m_valid;
         end
      end
   end

   initial begin
      int w;
      int x;
      int y;
      int k;

      repeat (3) @(posedge clk);
      #1;
      check("rst_s_ready", int'(s_ready), 1, 0);
      check("rst_busy", int'(busy), 0, 0);
      check("rst_m_valid", int'(m_valid), 0, 0);
      check("rst_x_o", int'(x_o), 0, 0);
      check("rst_y_o", int'(y_o), 0, 0);
      rst_n = 1'b1;

      for (int q = 0; q < 4; q++) begin
         send(2'(q), 0, 16384, 0, TOL_DIR, TOL_DIR);
      end
      send(2'd0, 32768, 16384, 0, TOL_DIR, TOL_DIR);
      send(2'd0, 32768, 32767, 32767, TOL_DIR, 0);
      send(2'd2, 0, -32768, 0, TOL_DIR, TOL_DIR);
      drain();

      // Result held under backpressure while a second request waits at the input.
      rdy_mode = 2;
      send(2'd0, 32768, 16384, 0, TOL_DIR, TOL_DIR);
      drive(2'd1, 12000, 9000, -7000);
      k = 0;
      while (!m_valid && k < LIMIT) begin
         @(negedge clk);
         k++;
      end
      check("bp_valid_seen", int'(m_valid), 1, 0);
      for (int i = 0; i < 5; i++) begin
         check("bp_s_ready", int'(s_ready), 0, 0);
         @(negedge clk);
      end
      rdy_mode = 0;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(m_valid && m_ready) && k < LIMIT);
      check("bp_handshake", int'(m_valid && m_ready), 1, 0);
      accept(2'd1, 12000, 9000, -7000, TOL_DIR, TOL_DIR, w);
      check("bp_accept_delay", w, 1, 0);
      drain();

      // Reset in the middle of a rotation discards the transaction.
      send(2'd0, 0, 16384, 0, TOL_DIR, TOL_DIR);
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_s_ready", int'(s_ready), 1, 0);
      check("arst_busy", int'(busy), 0, 0);
      check("arst_m_valid", int'(m_valid), 0, 0);
      check("arst_x_o", int'(x_o), 0, 0);
      check("arst_y_o", int'(y_o), 0, 0);
      sb.delete();
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < N + 6; i++) begin
         @(negedge clk);
         check("post_rst_m_valid", int'(m_valid), 0, 0);
      end
      check("post_rst_s_ready", int'(s_ready), 1, 0);

      rdy_mode = 1;
      for (int i = 0; i < 40; i++) begin
         x = int'($urandom_range(0, 46340)) - 23170;
         y = int'($urandom_range(0, 46340)) - 23170;
         repeat ($urandom_range(0, 3)) @(posedge clk);
         send(2'($urandom_range(0, 3)), int'($urandom_range(0, 65535)), x, y, TOL_RND, TOL_RND);
      end
      drain();
      rdy_mode = 0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
